// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memories library.
//   RDW_*      : read-during-write mode selectors for single-port RAMs
//   num_lanes  : number of byte-enable lanes in a word
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int RDW_READ_FIRST  = 0;  // write access returns the old word
  localparam int RDW_WRITE_FIRST = 1;  // write access returns the merged word
  localparam int RDW_NO_CHANGE   = 2;  // write access leaves read data as is

  function automatic int num_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_sp_param_if.sv
// ---------------------------------------------------------------------------
// ram_sp_param_if
// Single-port RAM access bus.
//   en        : port enable (no read or write when low)
//   we        : write enable, qualified by en
//   be        : byte-lane write mask, qualified by en & we
//   addr      : word address
//   data_in   : write data
//   data_out  : registered read data
//   valid_out : one-cycle flag marking a new read result on data_out
// master = requester, slave = RAM.
// ---------------------------------------------------------------------------
interface ram_sp_param_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);

  localparam int LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);

  logic                  en;
  logic                  we;
  logic [LANES-1:0]      be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;

  modport master (
    output en, we, be, addr, data_in,
    input  data_out, valid_out
  );

  modport slave (
    input  en, we, be, addr, data_in,
    output data_out, valid_out
  );

endinterface

// File: rtl/ram_sp_core.sv
// ---------------------------------------------------------------------------
// ram_sp_core
// Storage array, byte-lane write merge and stage-1 read data register.
// Neither the array nor the read register has a reset; the read register
// only has a synchronous clear that the wrapper drives during reset.
//   clk      : clock
//   clr      : synchronous clear of the read register
//   rd_en    : qualified access (enable and not in reset)
//   we       : access is a write
//   in_range : addr < DEPTH
//   be       : byte-lane write mask
//   addr     : word address
//   data_in  : write data
//   rd_data  : stage-1 read data
// ---------------------------------------------------------------------------
module ram_sp_core
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                                          clk,
  input  logic                                          clr,
  input  logic                                          rd_en,
  input  logic                                          we,
  input  logic                                          in_range,
  input  logic [num_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0]  be,
  input  logic [ADDR_WIDTH-1:0]                         addr,
  input  logic [DATA_WIDTH-1:0]                         data_in,
  output logic [DATA_WIDTH-1:0]                         rd_data
);

  localparam int LANES = num_lanes(DATA_WIDTH, BYTE_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  wr_commit;

  // Out-of-range writes are dropped here; the read side returns zero.
  assign wr_commit = rd_en & we & in_range;

  // NOTE: every variable gets its default at the top of always_comb so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    old_word    = in_range ? mem[addr] : '0;
    merged_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) merged_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // NOTE: the array has no reset: clearing it would need a multi-cycle
  // sweep or turn the RAM into flops, and callers never rely on contents
  // after power-up.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr] <= merged_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values, whatever the process order.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (we && RDW_MODE == RDW_NO_CHANGE) begin
        // Write access in NO_CHANGE mode: read data holds, even when the
        // address is out of range.
        rd_data <= rd_data;
      end else if (we && RDW_MODE == RDW_WRITE_FIRST) begin
        rd_data <= in_range ? merged_word : '0;
      end else begin
        rd_data <= old_word;
      end
    end
  end

endmodule

// File: rtl/ram_sp_param.sv
// ---------------------------------------------------------------------------
// ram_sp_param
// Parametrised single-port synchronous RAM with byte-lane write enables,
// selectable read-during-write behaviour, optional output register stage
// and a read-valid flag.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (clears output path, not memory)
//   bus   : ram_sp_param_if.slave (en, we, be, addr, data_in,
//           data_out, valid_out)
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
// ---------------------------------------------------------------------------
module ram_sp_param
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int RDW_MODE   = RDW_READ_FIRST,
  parameter int OUT_REG    = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_sp_param_if.slave  bus
);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("ram_sp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("ram_sp_param: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (RDW_MODE > RDW_NO_CHANGE) begin : g_bad_mode
    $error("ram_sp_param: RDW_MODE must be 0, 1 or 2");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  in_range;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  assign in_range = ({1'b0, bus.addr} < DEPTH_LIMIT);
  // An access presented on a reset edge is dropped entirely.
  assign rd_en    = rst_n & bus.en;

  ram_sp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .RDW_MODE   (RDW_MODE)
  ) u_core (
    .clk      (clk),
    .clr      (~rst_n),
    .rd_en    (rd_en),
    .we       (bus.we),
    .in_range (in_range),
    .be       (bus.be),
    .addr     (bus.addr),
    .data_in  (bus.data_in),
    .rd_data  (s1_data)
  );

  // Every access, write or read, in or out of range, yields one result.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= bus.en;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;

    // Not gated by en, so the pipeline drains after the last access.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end else begin
        out_data  <= s1_data;
        out_valid <= s1_valid;
      end
    end

    assign bus.data_out  = out_data;
    assign bus.valid_out = out_valid;
  end else begin : g_no_out_reg
    assign bus.data_out  = s1_data;
    assign bus.valid_out = s1_valid;
  end

endmodule

// File: tb/tb_ram_sp_param.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_param
// Five RAM instances share one stimulus stream:
//   u0: 32-bit, DEPTH 48, READ_FIRST
//   u1: 32-bit, DEPTH 48, WRITE_FIRST
//   u2: 32-bit, DEPTH 48, NO_CHANGE
//   u3: 32-bit, DEPTH 48, READ_FIRST, OUT_REG=1
//   u4: defaults (8-bit, DEPTH 64), fed lane 0 of the stimulus
// A word-level reference model predicts every output after every edge.
// ---------------------------------------------------------------------------
module tb_ram_sp_param;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, we;
  logic [3:0]  be;
  logic [5:0]  addr;
  logic [31:0] din;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sp_param_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if0 ();
  ram_sp_param_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if1 ();
  ram_sp_param_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if2 ();
  ram_sp_param_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6)) if3 ();
  ram_sp_param_if if4 ();

  assign if0.en = en;  assign if0.we = we;  assign if0.be = be;  assign if0.addr = addr;  assign if0.data_in = din;
  assign if1.en = en;  assign if1.we = we;  assign if1.be = be;  assign if1.addr = addr;  assign if1.data_in = din;
  assign if2.en = en;  assign if2.we = we;  assign if2.be = be;  assign if2.addr = addr;  assign if2.data_in = din;
  assign if3.en = en;  assign if3.we = we;  assign if3.be = be;  assign if3.addr = addr;  assign if3.data_in = din;
  assign if4.en = en;  assign if4.we = we;  assign if4.be = be[0]; assign if4.addr = addr; assign if4.data_in = din[7:0];

  ram_sp_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48),
                 .RDW_MODE(RDW_READ_FIRST), .OUT_REG(0))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  ram_sp_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48),
                 .RDW_MODE(RDW_WRITE_FIRST), .OUT_REG(0))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ram_sp_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48),
                 .RDW_MODE(RDW_NO_CHANGE), .OUT_REG(0))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  ram_sp_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(6), .DEPTH(48),
                 .RDW_MODE(RDW_READ_FIRST), .OUT_REG(1))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  ram_sp_param u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic [31:0] act_d [5];
  logic        act_v [5];
  assign act_d[0] = if0.data_out;         assign act_v[0] = if0.valid_out;
  assign act_d[1] = if1.data_out;         assign act_v[1] = if1.valid_out;
  assign act_d[2] = if2.data_out;         assign act_v[2] = if2.valid_out;
  assign act_d[3] = if3.data_out;         assign act_v[3] = if3.valid_out;
  assign act_d[4] = {24'h0, if4.data_out}; assign act_v[4] = if4.valid_out;

  // ---------------- reference model ----------------
  int          mode_k   [5] = '{RDW_READ_FIRST, RDW_WRITE_FIRST, RDW_NO_CHANGE, RDW_READ_FIRST, RDW_READ_FIRST};
  bit          outreg_k [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] m32 [48];
  logic [7:0]  m8  [64];
  logic [31:0] last_d [5];   // most recent read result (0 after reset)
  logic        last_v [5];   // an access happened at the latest edge
  logic [31:0] late_d [5];   // the same values one edge older
  logic        late_v [5];

  task automatic model(input logic r, input logic e, input logic w,
                       input logic [3:0] b, input logic [5:0] a, input logic [31:0] d);
    logic [31:0] old32, mrg32, res;
    logic [7:0]  old8, mrg8;
    bit          in32;
    in32  = (a < 6'd48);
    old32 = in32 ? m32[int'(a)] : 32'h0;
    mrg32 = old32;
    for (int i = 0; i < 4; i++) if (b[i]) mrg32[i*8 +: 8] = d[i*8 +: 8];
    old8  = m8[int'(a)];
    mrg8  = b[0] ? d[7:0] : old8;
    for (int k = 0; k < 5; k++) begin
      if (!r) begin
        last_d[k] = '0; last_v[k] = 1'b0; late_d[k] = '0; late_v[k] = 1'b0;
      end else begin
        late_d[k] = last_d[k];
        late_v[k] = last_v[k];
        last_v[k] = e;
        if (e) begin
          if (k == 4)                              res = {24'h0, old8};
          else if (w && mode_k[k] == RDW_NO_CHANGE)   res = last_d[k];
          else if (w && mode_k[k] == RDW_WRITE_FIRST) res = in32 ? mrg32 : 32'h0;
          else                                     res = old32;
          last_d[k] = res;
        end
      end
    end
    if (r && e && w) begin
      if (in32) m32[int'(a)] = mrg32;
      m8[int'(a)] = mrg8;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, and compare after the edge.
  task automatic step(input logic r, input logic e, input logic w, input logic [3:0] b,
                      input logic [5:0] a, input logic [31:0] d, input bit do_check);
    rst_n = r; en = e; we = w; be = b; addr = a; din = d;
    model(r, e, w, b, a, d);
    @(posedge clk);
    #1;
    if (do_check) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("u%0d data_out", k), act_d[k], outreg_k[k] ? late_d[k] : last_d[k]);
        check($sformatf("u%0d valid_out", k), {31'h0, act_v[k]},
              {31'h0, outreg_k[k] ? late_v[k] : last_v[k]});
      end
    end
  endtask

  typedef struct {
    logic        r, e, w;
    logic [3:0]  b;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] xd;  // expected u0 data_out after the edge
    logic        xv;  // expected u0 valid_out after the edge
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Directed vectors for u0 (READ_FIRST, latency 1, DEPTH 48); the
    // memory is preloaded with word a = 0x01010101 * a beforehand.
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 4'hF, 6'd3,  32'hAAAAAAAA, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'hF, 6'd3,  32'hAAAAAAAA, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 6'd3,  32'h0,        32'h03030303, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 4'hF, 6'd10, 32'h0000005C, 32'h0A0A0A0A, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 6'd10, 32'h0,        32'h0000005C, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'h0, 6'd10, 32'h0,        32'h0000005C, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'hF, 6'd0,  32'h11223344, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'h5, 6'd0,  32'hAABBCCDD, 32'h11223344, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 6'd0,  32'h0,        32'h11BB33DD, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'hF, 6'd5,  32'h00000012, 32'h05050505, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'hF, 6'd5,  32'h00000034, 32'h00000012, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 4'hF, 6'd50, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4'h0, 6'd50, 32'h0,        32'h00000000, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 6'd2,  32'h0,        32'h02020202, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 4'h0, 6'd6,  32'h0,        32'h06060606, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 4'h0, 6'd6,  32'h0,        32'h06060606, 1'b1};

    for (int i = 0; i < 48; i++) m32[i] = '0;
    for (int i = 0; i < 64; i++) m8[i]  = '0;
    for (int k = 0; k < 5; k++) begin
      last_d[k] = '0; last_v[k] = 1'b0; late_d[k] = '0; late_v[k] = 1'b0;
    end
    rst_n = 1'b0; en = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;

    // Preload every address (unchecked: unwritten RAM reads are undefined).
    step(1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0);
    for (int a = 0; a < 64; a++)
      step(1'b1, 1'b1, 1'b1, 4'hF, 6'(a), 32'h01010101 * a, 1'b0);

    // Table-driven directed vectors.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, 1'b1);
      check($sformatf("tbl%0d u0 data_out", i), act_d[0], tbl[i].xd);
      check($sformatf("tbl%0d u0 valid_out", i), {31'h0, act_v[0]}, {31'h0, tbl[i].xv});
    end
    // Write 0x34 over 0x12 at addr 5 was row 10: WRITE_FIRST saw the new
    // data, NO_CHANGE kept what it held after row 8.
    // (Covered by the model; rows 11+ moved the outputs on since.)

    // OUT_REG=1: back-to-back reads of 1,2,3 emerge two edges later.
    step(1'b1, 1'b1, 1'b0, 4'h0, 6'd1, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 6'd2, 32'h0, 1'b1);
    check("oreg rd1 data", act_d[3], 32'h01010101);
    check("oreg rd1 valid", {31'h0, act_v[3]}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 6'd3, 32'h0, 1'b1);
    check("oreg rd2 data", act_d[3], 32'h02020202);
    check("oreg rd2 valid", {31'h0, act_v[3]}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1);
    check("oreg rd3 data", act_d[3], 32'h03030303);
    check("oreg rd3 valid", {31'h0, act_v[3]}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1);
    check("oreg drained valid", {31'h0, act_v[3]}, 32'h0);
    check("oreg drained data", act_d[3], 32'h03030303);

    // Reset mid-stream clears in-flight valids in both stages.
    step(1'b1, 1'b1, 1'b0, 4'h0, 6'd1, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 6'd2, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'h0, 6'd3, 32'h0, 1'b1);
    check("oreg reset valid", {31'h0, act_v[3]}, 32'h0);
    check("oreg reset data", act_d[3], 32'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1);
    check("oreg post-reset valid", {31'h0, act_v[3]}, 32'h0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(31) != 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
           4'($urandom), 6'($urandom), $urandom, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
Parametrised single-port synchronous RAM. It generalises the fixed 64x8 single-port RAM to arbitrary width and depth, and adds byte-lane write enables, a selectable read-during-write mode, an optional output pipeline register and a read-valid flag. It serves as the standard scratch/buffer memory for datapath blocks in the memories library.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane
ADDR_WIDTH, 6, address width
DEPTH, 64, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
RDW_MODE, 0, read-during-write: 0=READ_FIRST (old data), 1=WRITE_FIRST (new data), 2=NO_CHANGE (data_out holds)
OUT_REG, 0, 1 adds a second output register stage (read latency 2)

Ports:
clk  in  1  clock; all logic on its rising edge
rst_n  in  1  reset
en  in  1  port enable; no read or write when low
we  in  1  write enable, qualified by en
be  in  DATA_WIDTH/BYTE_WIDTH  byte-lane write mask, qualified by en&we
addr  in  ADDR_WIDTH  word address
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  read data, registered
valid_out  out  1  high for one cycle when data_out carries a new read result

Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n=0 at a clk edge): data_out=0, valid_out=0, internal stage-1 data/valid=0. Memory contents are not cleared. Writes are suppressed while rst_n=0.
- Access: an access occurs at an edge with en=1. With en=0, memory is unchanged, stage-1 data holds, and stage-1 valid goes 0.
- Write: en=1, we=1. For each lane i with be[i]=1, mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in lane i. Lanes with be=0 are untouched. we=1 with be=0 is a legal no-op write that still counts as an access.
- Read: every access reads mem[addr], including writes.
- Stage-1 data result per mode:
  - READ_FIRST: pre-write word.
  - WRITE_FIRST: merged word (written lanes new, others old).
  - NO_CHANGE: stage-1 data holds its value on a write access; valid still asserts.
  - Reads with we=0 behave identically in all modes.
- Latency:
  - OUT_REG=0: data_out/valid_out are the stage-1 registers; data valid the cycle after the access edge.
  - OUT_REG=1: a second register copies stage-1 data/valid each cycle, giving latency 2. The output stage is not gated by en, so the pipeline drains.
- valid_out: asserts exactly once per access, after the latency; deasserts otherwise. Back-to-back accesses give continuous valid_out.
- Out-of-range (addr >= DEPTH, only possible when DEPTH < 2**ADDR_WIDTH): write ignored; read data = 0; valid_out still asserts.
- Reset mid-operation: an access presented in the same cycle as rst_n=0 is dropped. Any in-flight valid in either stage is cleared.
- No handshake/backpressure; a new access is accepted every cycle.

Decomposition:
- Shared package mem_pkg holds:
  - RDW mode constants RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2
  - function num_lanes(DATA_WIDTH, BYTE_WIDTH)
- Natural sub-module: ram_sp_core (storage array plus byte-lane write merge and stage-1 read register, unreset). The top adds valid tracking, reset of output regs, the OUT_REG stage and the range check.
- Elaboration check: fail if DATA_WIDTH % BYTE_WIDTH != 0, DEPTH > 2**ADDR_WIDTH, or RDW_MODE > 2.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with en=1, we=1, addr=3, data_in=0xAA -> data_out=0, valid_out=0; after release, read addr 3 -> not 0xAA (write suppressed).
2. Basic write/read, defaults: write 0x5C to addr 10, then read addr 10 -> data_out=0x5C with valid_out=1 exactly one cycle after the read edge; en=0 next cycle -> valid_out=0, data_out holds 0x5C.
3. Byte enables (DATA_WIDTH=32): write 0x11223344 to addr 0 with be=4'hF, then 0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD.
4. RDW modes: mem[5]=0x12, write 0x34 to addr 5. READ_FIRST -> data_out=0x12; WRITE_FIRST -> 0x34; NO_CHANGE -> previous data_out retained. valid_out=1 in all three.
5. OUT_REG=1: back-to-back reads of addrs 1,2,3 holding 0x01,0x02,0x03 -> outputs appear at cycles +2,+3,+4 with valid_out high for 3 consecutive cycles; rst_n=0 mid-stream clears valid_out next edge.
6. Out-of-range (DEPTH=48, ADDR_WIDTH=6): write 0xFF to addr 50, then read addr 50 -> data_out=0, valid_out=1; mem[50-48] is unchanged.
